// File: rtl/l2_bus_pkg.sv
// Shared types for the L2 bus responder: op and snoop encodings, FSM state codes, helpers.
package l2_bus_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_RFO   = 2'd2,
    OP_INVAL = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2
  } snoop_t;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SNOOP = 3'd1;
  localparam state_t ST_WB    = 3'd2;
  localparam state_t ST_MEM   = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

  // Encoding 3 on the snoop bus is reserved; treat it as a modified hit.
  function automatic snoop_t norm_snoop(input logic [1:0] r);
    snoop_t s;
    case (r)
      2'd0:    s = SNP_NOHIT;
      2'd1:    s = SNP_HIT;
      default: s = SNP_HITM;
    endcase
    return s;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/l2_bus_lat_counter.sv
// Reloadable down-counter shared by the SNOOP, WB and MEM phases; done is high while the count is 1.
module l2_bus_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (start) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/l2_bus_responder.sv
// Responder end of the L2 bus: snoop broadcast, write-back/memory latency, response with snoop result.
// Optional per-op request counters on stat_* when L2_BUS_STATS_EN is defined.
module l2_bus_responder
  import l2_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int MEM_LAT  = 4,
  parameter int WB_LAT   = 4,
  parameter int SNOOP_TO = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              snp_valid,
  output logic [1:0]        snp_op,
  output logic [ADDR_W-1:0] snp_addr,
  input  logic              snp_done,
  input  logic [1:0]        snp_result,
  output logic              mem_busy,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_snoop,
  output logic              rsp_err,
  output logic [15:0]       stat_rd,
  output logic [15:0]       stat_wr,
  output logic [15:0]       stat_rfo,
  output logic [15:0]       stat_inv,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready is high only in IDLE; rsp_valid holds with stable payload until rsp_ready.

  localparam int CNT_W = $clog2(max3(MEM_LAT, WB_LAT, SNOOP_TO) + 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

  state_t            state, state_nxt;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  snoop_t            snoop_q;
  logic              err_q;

  logic              cnt_start;
  logic [CNT_W-1:0]  cnt_load;
  logic              cnt_done;

  logic              accept;
  logic              snoop_exit;
  snoop_t            snoop_now;
  logic              snoop_hitm;

  assign accept     = (state == ST_IDLE) && req_valid;
  // snp_done takes priority over timeout expiry in the same cycle.
  assign snoop_exit = (state == ST_SNOOP) && (snp_done || cnt_done);
  assign snoop_now  = snp_done ? norm_snoop(snp_result) : SNP_NOHIT;
  assign snoop_hitm = (snoop_now == SNP_HITM);

  l2_bus_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat (
    .clk      (clk),
    .rst      (rst),
    .start    (cnt_start),
    .load_val (cnt_load),
    .done     (cnt_done)
  );

  always_comb begin
    state_nxt = state;
    cnt_start = 1'b0;
    cnt_load  = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt = ST_SNOOP;
          cnt_start = 1'b1;
          cnt_load  = CNT_W'(SNOOP_TO);
        end
      end
      ST_SNOOP: begin
        if (snoop_exit) begin
          if (op_q == OP_INVAL) begin
            state_nxt = ST_RESP;
          end else if (snoop_hitm && op_q == OP_WRITE) begin
            state_nxt = ST_RESP;
          end else if (snoop_hitm) begin
            state_nxt = ST_WB;
            cnt_start = 1'b1;
            cnt_load  = CNT_W'(WB_LAT);
          end else begin
            state_nxt = ST_MEM;
            cnt_start = 1'b1;
            cnt_load  = CNT_W'(MEM_LAT);
          end
        end
      end
      ST_WB: begin
        if (cnt_done) begin
          state_nxt = ST_MEM;
          cnt_start = 1'b1;
          cnt_load  = CNT_W'(MEM_LAT);
        end
      end
      ST_MEM: begin
        if (cnt_done) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      snoop_q <= SNP_NOHIT;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= op_t'(req_op);
        addr_q <= req_addr & LINE_MASK;
      end
      if (snoop_exit) begin
        snoop_q <= snoop_now;
        err_q   <= snoop_hitm && (op_q == OP_WRITE);
      end
      if (state == ST_RESP && rsp_ready) err_q <= 1'b0;
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign snp_valid = (state == ST_SNOOP);
  assign snp_op    = op_q;
  assign snp_addr  = addr_q;
  assign mem_busy  = (state == ST_WB) || (state == ST_MEM);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_snoop = snoop_q;
  assign rsp_err   = err_q;
  assign dbg_state = state;

`ifdef L2_BUS_STATS_EN
  logic [15:0] cnt_rd, cnt_wr, cnt_rfo, cnt_inv;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_rd  <= '0;
      cnt_wr  <= '0;
      cnt_rfo <= '0;
      cnt_inv <= '0;
    end else if (accept) begin
      case (op_t'(req_op))
        OP_READ:  cnt_rd  <= sat_inc16(cnt_rd);
        OP_WRITE: cnt_wr  <= sat_inc16(cnt_wr);
        OP_RFO:   cnt_rfo <= sat_inc16(cnt_rfo);
        default:  cnt_inv <= sat_inc16(cnt_inv);
      endcase
    end
  end

  assign stat_rd  = cnt_rd;
  assign stat_wr  = cnt_wr;
  assign stat_rfo = cnt_rfo;
  assign stat_inv = cnt_inv;
`else
  assign stat_rd  = 16'd0;
  assign stat_wr  = 16'd0;
  assign stat_rfo = 16'd0;
  assign stat_inv = 16'd0;
`endif

endmodule

// File: tb/tb_l2_bus_responder.sv
// Directed bench for l2_bus_responder: latency, snoop outcomes, timeout, reset abort and stats.
module tb_l2_bus_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic        snp_valid;
  logic [1:0]  snp_op;
  logic [31:0] snp_addr;
  logic        snp_done;
  logic [1:0]  snp_result;
  logic        mem_busy;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_snoop;
  logic        rsp_err;
  logic [15:0] stat_rd, stat_wr, stat_rfo, stat_inv;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  l2_bus_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .snp_valid  (snp_valid),
    .snp_op     (snp_op),
    .snp_addr   (snp_addr),
    .snp_done   (snp_done),
    .snp_result (snp_result),
    .mem_busy   (mem_busy),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_snoop  (rsp_snoop),
    .rsp_err    (rsp_err),
    .stat_rd    (stat_rd),
    .stat_wr    (stat_wr),
    .stat_rfo   (stat_rfo),
    .stat_inv   (stat_inv),
    .dbg_state  (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, answer the snoop after d SNOOP cycles (d<0: never), then retire the response.
  // Latency counts edges from the accept edge (inclusive) to the edge that raises rsp_valid.
  task automatic run_txn(input string tag, input logic [1:0] op, input logic [31:0] addr,
                         input int d, input logic [1:0] res, input int exp_lat,
                         input logic [1:0] exp_snp, input logic exp_err, input logic exp_mem);
    int k;
    int w;
    logic got;
    logic mem_seen;
    logic [1:0] exp_s;
    w = 0;
    while (!req_ready && w < 50) begin
      tick();
      w++;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    exp_q.push_back(exp_snp);
    tick();
    req_valid = 1'b0;
    check({tag, "_snp_valid"}, {31'd0, snp_valid}, 32'd1);
    check({tag, "_snp_addr"}, snp_addr, addr & 32'hFFFF_FFC0);
    check({tag, "_snp_op"}, {30'd0, snp_op}, {30'd0, op});
    check({tag, "_req_ready_busy"}, {31'd0, req_ready}, 32'd0);
    k = 0;
    got = 1'b0;
    mem_seen = 1'b0;
    while (k < 40 && !got) begin
      if (d >= 0 && k == d) begin
        snp_done   = 1'b1;
        snp_result = res;
      end else begin
        snp_done = 1'b0;
      end
      tick();
      k++;
      if (mem_busy) mem_seen = 1'b1;
      if (rsp_valid) got = 1'b1;
    end
    snp_done = 1'b0;
    check({tag, "_latency"}, got ? k + 1 : 0, exp_lat);
    check({tag, "_mem_busy_seen"}, {31'd0, mem_seen}, {31'd0, exp_mem});
    exp_s = exp_q.pop_front();
    if (got) begin
      check({tag, "_rsp_snoop"}, {30'd0, rsp_snoop}, {30'd0, exp_s});
      check({tag, "_rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      tick();
      tick();
      check({tag, "_rsp_hold"}, {29'd0, rsp_valid, rsp_snoop}, {29'd0, 1'b1, exp_s});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, "_post_req_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_post_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_post_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    end
  endtask

  initial begin
    logic [15:0] e_rd, e_wr, e_rfo, e_inv;
    logic seen_rsp;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'd0;
    req_addr   = 32'd0;
    snp_done   = 1'b0;
    snp_result = 2'd0;
    rsp_ready  = 1'b0;
    repeat (3) tick();
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_outputs", {28'd0, snp_valid, mem_busy, rsp_valid, rsp_err}, 32'd0);
    check("reset_snp_addr", snp_addr, 32'd0);
    check("reset_state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    tick();

    // snp_done while idle must not start anything nor leak into the next response
    snp_done   = 1'b1;
    snp_result = 2'd2;
    repeat (3) tick();
    snp_done = 1'b0;
    check("idle_snp_ignored", {30'd0, req_ready, snp_valid}, 32'd2);

    // tag, op, addr, snoop delay, result, latency, rsp_snoop, rsp_err, mem phase
    run_txn("read_nohit",   2'd0, 32'h0000_1234, 2,  2'd0, 8,  2'd0, 1'b0, 1'b1);
    run_txn("rfo_hitm",     2'd2, 32'h8000_0047, 0,  2'd2, 10, 2'd2, 1'b0, 1'b1);
    run_txn("write_hitm",   2'd1, 32'h1234_5678, 1,  2'd2, 3,  2'd2, 1'b1, 1'b0);
    run_txn("inval_to",     2'd3, 32'hDEAD_BEEF, -1, 2'd0, 9,  2'd0, 1'b0, 1'b0);
    run_txn("read_res3",    2'd0, 32'h0000_00FF, 0,  2'd3, 10, 2'd2, 1'b0, 1'b1);
    run_txn("read_tie_hit", 2'd0, 32'hFFFF_FFFF, 7,  2'd1, 13, 2'd1, 1'b0, 1'b1);
    run_txn("write_hit",    2'd1, 32'h0000_0040, 0,  2'd1, 6,  2'd1, 1'b0, 1'b1);

    // Reset during MEM with the response side stalled
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_addr  = 32'h0000_2000;
    tick();
    req_valid  = 1'b0;
    snp_done   = 1'b1;
    snp_result = 2'd0;
    tick();
    snp_done = 1'b0;
    tick();
    check("abort_in_mem", {31'd0, mem_busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_outputs", {27'd0, snp_valid, mem_busy, rsp_valid, rsp_err, req_ready}, 32'd1);
    check("abort_snp_addr", snp_addr, 32'd0);
    check("abort_stats", {stat_rd, stat_wr} | {stat_rfo, stat_inv}, 32'd0);
    seen_rsp = 1'b0;
    repeat (12) begin
      tick();
      if (rsp_valid) seen_rsp = 1'b1;
    end
    check("abort_no_rsp", {31'd0, seen_rsp}, 32'd0);

    // Stats mix: 3 READ + 1 RFO + 2 INVAL, all answered NOHIT on the first snoop cycle
    run_txn("st_rd0",  2'd0, 32'h0000_0100, 0, 2'd0, 6, 2'd0, 1'b0, 1'b1);
    run_txn("st_inv0", 2'd3, 32'h0000_0200, 0, 2'd0, 2, 2'd0, 1'b0, 1'b0);
    run_txn("st_rd1",  2'd0, 32'h0000_0300, 0, 2'd0, 6, 2'd0, 1'b0, 1'b1);
    run_txn("st_rfo0", 2'd2, 32'h0000_0400, 0, 2'd0, 6, 2'd0, 1'b0, 1'b1);
    run_txn("st_inv1", 2'd3, 32'h0000_0500, 0, 2'd0, 2, 2'd0, 1'b0, 1'b0);
    run_txn("st_rd2",  2'd0, 32'h0000_0600, 0, 2'd0, 6, 2'd0, 1'b0, 1'b1);
`ifdef L2_BUS_STATS_EN
    e_rd = 16'd3; e_wr = 16'd0; e_rfo = 16'd1; e_inv = 16'd2;
`else
    e_rd = 16'd0; e_wr = 16'd0; e_rfo = 16'd0; e_inv = 16'd0;
`endif
    check("stat_rd",  {16'd0, stat_rd},  {16'd0, e_rd});
    check("stat_wr",  {16'd0, stat_wr},  {16'd0, e_wr});
    check("stat_rfo", {16'd0, stat_rfo}, {16'd0, e_rfo});
    check("stat_inv", {16'd0, stat_inv}, {16'd0, e_inv});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
